// File: rtl/fifo_rd_stream.sv
// Read side of a 1-cycle-latency fifo turned into a valid/ready stream.
// A 3-entry skid buffer plus one in-flight slot lets reads continue without a combinational path from m_ready.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 3
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occ
);

  logic             run;
  logic             inflight;
  logic [1:0]       occ_q, occ_d, wr_idx;
  logic [2:0]       pending;
  logic             pop, capture;
  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [WIDTH-1:0] buf_d [BUF_DEPTH];

  // Reads in flight count against free space, so a returning word always has a slot.
  assign pending    = {1'b0, occ_q} + {2'b0, inflight};
  assign fifo_rd_en = run && !fifo_empty && !flush && (pending < 3'd3);

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[0];
  assign occ     = occ_q;
  assign pop     = m_valid && m_ready;
  assign capture = inflight && !flush;
  assign wr_idx  = occ_q - {1'b0, pop};

  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) buf_d[i] = buf_q[i];
    if (pop)
      for (int i = 0; i < BUF_DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
    // Captured word lands right behind whatever survives this cycle's pop.
    for (int i = 0; i < BUF_DEPTH; i++)
      if (capture && wr_idx == 2'(i)) buf_d[i] = fifo_data;
    occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
    if (flush) occ_d = 2'd0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      occ_q    <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_rd_en;
      occ_q    <= occ_d;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: cycle table for the basic and back-pressure flows, hand sequences for
// toggled ready, flush, async reset and empty-after-read.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       flush = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [1:0] occ;

  int checks = 0;
  int failures = 0;

  // Upstream fifo model: 1-cycle read latency.
  logic [7:0] mem [256];
  int         wp = 0;
  int         rp = 0;
  logic       force_empty = 1'b0;

  assign fifo_empty = force_empty || (rp == wp);

  always @(posedge clk)
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rp[7:0]];
      rp        <= rp + 1;
    end

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(8), .BUF_DEPTH(3)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .occ        (occ)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp[7:0]] = v;
    wp = wp + 1;
  endtask

  always @(negedge clk)
    if (arst_n === 1'b1) begin
      assert (!$isunknown(occ)) else $error("occ unknown");
      chk("valid_vs_occ", {31'b0, m_valid}, {31'b0, (occ != 2'd0)});
    end

  typedef struct {
    int         npush;
    logic [7:0] pbase;
    logic       rdy;
    logic       fl;
    logic       erd;
    logic       evld;
    logic [7:0] edat;
    logic [1:0] eocc;
  } vec_t;

  vec_t tv[18];

  initial begin
    int         got;
    int         n;
    logic       stalled;
    logic [7:0] prev;

    tv[0]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[2]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
    tv[3]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
    tv[4]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 2'd1};
    tv[5]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    tv[6]  = '{5, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[7]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tv[8]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1};
    tv[9]  = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2};
    tv[10] = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3};
    tv[11] = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3};
    tv[12] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3};
    tv[13] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd2};
    tv[14] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2'd1};
    tv[15] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 2'd1};
    tv[16] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd1};
    tv[17] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

    // Reset state with a loaded fifo.
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_occ",   {30'b0, occ}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data",  {24'b0, m_data}, 32'd0);
    chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1 chk("run_not_set", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);

    for (int r = 0; r < 18; r++) begin
      for (int k = 0; k < tv[r].npush; k++) push(tv[r].pbase + 8'(k));
      m_ready = tv[r].rdy;
      flush   = tv[r].fl;
      #1;
      chk($sformatf("tv%0d_rd_en", r), {31'b0, fifo_rd_en}, {31'b0, tv[r].erd});
      chk($sformatf("tv%0d_valid", r), {31'b0, m_valid}, {31'b0, tv[r].evld});
      chk($sformatf("tv%0d_occ", r),   {30'b0, occ}, {30'b0, tv[r].eocc});
      if (tv[r].evld)
        chk($sformatf("tv%0d_data", r), {24'b0, m_data}, {24'b0, tv[r].edat});
      @(negedge clk);
    end

    // Ready toggling 1010 over a 10-word stream.
    for (int k = 0; k < 10; k++) push(8'hB0 + 8'(k));
    got = 0;
    stalled = 1'b0;
    prev = 8'h00;
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 2 == 0);
      #1;
      if (stalled) begin
        chk("tog_hold_valid", {31'b0, m_valid}, 32'd1);
        chk("tog_hold_data", {24'b0, m_data}, {24'b0, prev});
      end
      if (m_valid && m_ready) begin
        chk("tog_order", {24'b0, m_data}, {24'b0, 8'hB0 + 8'(got)});
        got++;
      end
      stalled = m_valid && !m_ready;
      prev = m_data;
      @(negedge clk);
    end
    chk("tog_count", got, 32'd10);
    #1 chk("tog_occ_end", {30'b0, occ}, 32'd0);

    // Flush with two held and one in flight.
    @(negedge clk);
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    #1 chk("fl_rd0", {31'b0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("fl_occ1", {30'b0, occ}, 32'd1);
    @(negedge clk);
    #1 chk("fl_occ2", {30'b0, occ}, 32'd2);
    flush = 1'b1;
    #1 chk("fl_rd_blocked", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_occ_after", {30'b0, occ}, 32'd0);
    chk("fl_valid_after", {31'b0, m_valid}, 32'd0);
    chk("fl_rd_resume", {31'b0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    #1 chk("fl_no_stale", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("fl_next_valid", {31'b0, m_valid}, 32'd1);
    chk("fl_next_data", {24'b0, m_data}, 32'hC4);
    m_ready = 1'b1;
    @(negedge clk);
    #1 chk("fl_drained", {30'b0, occ}, 32'd0);

    // Async reset mid-transfer with occ=2.
    @(negedge clk);
    m_ready = 1'b0;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 chk("ar_occ2", {30'b0, occ}, 32'd2);
    #2 arst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, m_valid}, 32'd0);
    chk("ar_occ", {30'b0, occ}, 32'd0);
    chk("ar_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    #1 chk("ar_rd_hold", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    #1 chk("ar_rd_rise", {31'b0, fifo_rd_en}, 32'd1);
    m_ready = 1'b1;
    n = 0;
    while (!m_valid && n < 6) begin
      @(negedge clk); #1; n++;
    end
    chk("ar_drain_valid", {31'b0, m_valid}, 32'd1);
    chk("ar_drain_data", {24'b0, m_data}, 32'hE4);
    @(negedge clk);
    #1 chk("ar_drain_occ", {30'b0, occ}, 32'd0);

    // Fifo goes empty right after an accepted read.
    @(negedge clk);
    push(8'hD1); push(8'hD2);
    #1 chk("em_rd0", {31'b0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    force_empty = 1'b1;
    #1 chk("em_rd_off", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("em_inflight_valid", {31'b0, m_valid}, 32'd1);
    chk("em_inflight_data", {24'b0, m_data}, 32'hD1);
    chk("em_rd_still_off", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("em_no_extra", {31'b0, m_valid}, 32'd0);
    chk("em_rd_off2", {31'b0, fifo_rd_en}, 32'd0);
    force_empty = 1'b0;
    #1 chk("em_rd_back", {31'b0, fifo_rd_en}, 32'd1);
    n = 0;
    while (!m_valid && n < 6) begin
      @(negedge clk); #1; n++;
    end
    chk("em_d2_valid", {31'b0, m_valid}, 32'd1);
    chk("em_d2_data", {24'b0, m_data}, 32'hD2);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
